// File: rtl/key_event_debounce.sv
// key_event_debounce
//   Synchronizes and debounces an active-low key bank. Each debounced
//   transition becomes a press/release event, delivered through a one-entry
//   valid/ready output register.
//
// Ports
//   clk_i        system clock (only clock)
//   reset_i      synchronous, active-high reset
//   key_i        raw asynchronous keys, active-low (0 = pressed)
//   key_db_o     debounced key level, active-low
//   evt_valid_o  event presented
//   evt_code_o   index of the key that changed
//   evt_press_o  1 = press (1->0), 0 = release
//   evt_ready_i  consumer accepts the presented event
module key_event_debounce #(
  parameter int unsigned N_KEYS = 8,
  parameter int unsigned CW     = 3,
  parameter int unsigned DIV    = 2000,
  parameter int unsigned STABLE = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [N_KEYS-1:0] key_i,
  output logic [N_KEYS-1:0] key_db_o,
  output logic              evt_valid_o,
  output logic [CW-1:0]     evt_code_o,
  output logic              evt_press_o,
  input  logic              evt_ready_i
);

  localparam int unsigned TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SW = $clog2(STABLE) + 1;
  localparam logic [TW-1:0] TickLast = TW'(DIV - 1);
  localparam logic [SW-1:0] ScLast   = SW'(STABLE - 1);

  logic [N_KEYS-1:0] sync1_q, ks_q;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic              tick;

  logic [N_KEYS-1:0][SW-1:0] sc_q, sc_d;
  logic [N_KEYS-1:0]         db_q, db_d;
  logic [N_KEYS-1:0]         chg;
  logic [N_KEYS-1:0]         pend_q, pend_d;

  logic          valid_q, valid_d;
  logic [CW-1:0] code_q, code_d;
  logic          press_q, press_d;

  logic          slot_free;
  logic          found;
  logic [CW-1:0] low_idx;

  // Sample tick: one cycle out of every DIV.
  always_comb begin
    tick  = (cnt_q == TickLast);
    cnt_d = tick ? '0 : cnt_q + TW'(1);
  end

  // Per-key stability counting; a key flips only after STABLE consecutive
  // differing samples, any agreeing sample restarts the count.
  always_comb begin
    sc_d = sc_q;
    db_d = db_q;
    chg  = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (tick) begin
        if (ks_q[i] == db_q[i]) begin
          sc_d[i] = '0;
        end else if (sc_q[i] == ScLast) begin
          db_d[i]  = ks_q[i];
          sc_d[i]  = '0;
          chg[i]   = 1'b1;
        end else begin
          sc_d[i] = sc_q[i] + SW'(1);
        end
      end
    end
  end

  // Lowest pending index (descending scan so the lowest hit wins).
  always_comb begin
    found   = 1'b0;
    low_idx = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        found   = 1'b1;
        low_idx = CW'(i);
      end
    end
  end

  // Output slot and pending mask. A second toggle before issue cancels the
  // pending bit; the bit being issued takes only this cycle's change.
  always_comb begin
    slot_free = !valid_q || evt_ready_i;
    valid_d   = valid_q;
    code_d    = code_q;
    press_d   = press_q;
    pend_d    = pend_q ^ chg;
    if (slot_free) begin
      if (found) begin
        valid_d         = 1'b1;
        code_d          = low_idx;
        press_d         = ~db_q[low_idx];
        pend_d[low_idx] = chg[low_idx];
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= '1;
      ks_q    <= '1;
      cnt_q   <= '0;
      sc_q    <= '0;
      db_q    <= '1;
      pend_q  <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_i;
      ks_q    <= sync1_q;
      cnt_q   <= cnt_d;
      sc_q    <= sc_d;
      db_q    <= db_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      press_q <= press_d;
    end
  end

  assign key_db_o    = db_q;
  assign evt_valid_o = valid_q;
  assign evt_code_o  = code_q;
  assign evt_press_o = press_q;

endmodule

// File: tb/tb_key_event_debounce.sv
module tb_key_event_debounce;

  localparam int unsigned NK  = 8;
  localparam int unsigned CWB = 3;
  localparam int unsigned DV  = 4;
  localparam int unsigned ST  = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [NK-1:0]  key;
  logic [NK-1:0]  key_db;
  logic           evt_valid;
  logic [CWB-1:0] evt_code;
  logic           evt_press;
  logic           evt_ready;

  always #5 clk = ~clk;

  key_event_debounce #(
    .N_KEYS(NK),
    .CW    (CWB),
    .DIV   (DV),
    .STABLE(ST)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .key_i      (key),
    .key_db_o   (key_db),
    .evt_valid_o(evt_valid),
    .evt_code_o (evt_code),
    .evt_press_o(evt_press),
    .evt_ready_i(evt_ready)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: key history gives ks, an elapsed-cycle count gives
  // the tick, run lengths of differing samples give the debounced level.
  bit          m_init = 0;
  logic [NK-1:0] m_hist [2];
  logic [NK-1:0] m_db, m_pend, m_chg, m_newpend;
  int          m_run [NK];
  int          m_cyc;
  bit          m_valid, m_press;
  int          m_code;
  int          m_load;
  bit          m_tick;

  always @(posedge clk) begin
    if (reset) begin
      m_hist[0] = '1; m_hist[1] = '1;
      m_db = '1; m_pend = '0; m_cyc = 0;
      m_valid = 0; m_press = 0; m_code = 0;
      for (int i = 0; i < NK; i++) m_run[i] = 0;
      m_init = 1;
    end else if (m_init) begin
      m_tick = ((m_cyc % DV) == DV - 1);
      m_chg  = '0;
      if (m_tick) begin
        for (int i = 0; i < NK; i++) begin
          if (m_hist[1][i] == m_db[i]) m_run[i] = 0;
          else begin
            m_run[i] = m_run[i] + 1;
            if (m_run[i] == ST) begin
              m_chg[i] = 1'b1;
              m_run[i] = 0;
            end
          end
        end
      end
      m_load = -1;
      if (!m_valid || evt_ready) begin
        if (m_pend != 0) begin
          for (int i = NK - 1; i >= 0; i--) if (m_pend[i]) m_load = i;
          m_code  = m_load;
          m_press = !m_db[m_load];
          m_valid = 1;
        end else begin
          m_valid = 0;
        end
      end
      m_newpend = m_pend ^ m_chg;
      if (m_load >= 0) m_newpend[m_load] = m_chg[m_load];
      m_pend    = m_newpend;
      m_db      = m_db ^ m_chg;
      m_hist[1] = m_hist[0];
      m_hist[0] = key;
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("model key_db", {24'd0, key_db}, {24'd0, m_db});
      check("model evt_valid", {31'd0, evt_valid}, {31'd0, m_valid});
      if (m_valid) begin
        check("model evt_code", {29'd0, evt_code}, m_code);
        check("model evt_press", {31'd0, evt_press}, {31'd0, m_press});
      end
    end
  end

  task automatic wait_valid(input int bound, output bit ok);
    int n = 0;
    while (!evt_valid && n < bound) begin
      @(negedge clk);
      n++;
    end
    ok = evt_valid;
  endtask

  task automatic wait_db_bit(input int idx, input logic val, input int bound, output int n);
    n = 0;
    while (key_db[idx] !== val && n < bound) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  logic [NK-1:0] key_cur;
  int  n, vcnt, vcode, vpress;
  bit  ok;
  int  exp_codes [3] = '{0, 3, 7};

  initial begin
    reset = 1'b1; key = 8'hFE; evt_ready = 1'b1;
    // 1: reset
    repeat (3) @(negedge clk);
    check("reset key_db", {24'd0, key_db}, 32'hFF);
    check("reset evt_valid", {31'd0, evt_valid}, 0);
    reset = 1'b0; key = 8'hFF; key_cur = 8'hFF;
    @(negedge clk);
    check("post-reset key_db", {24'd0, key_db}, 32'hFF);
    check("post-reset evt_valid", {31'd0, evt_valid}, 0);

    // 2: clean press and release of key 2
    key_cur = 8'hFB; key = key_cur;
    wait_db_bit(2, 1'b0, 30, n);
    check("press key_db", {24'd0, key_db}, 32'hFB);
    check("press latency ok", {31'd0, n <= 14}, 1);
    vcnt = 0; vcode = -1; vpress = -1;
    repeat (8) begin
      @(negedge clk);
      if (evt_valid) begin vcnt++; vcode = evt_code; vpress = evt_press; end
    end
    check("press evt count", vcnt, 1);
    check("press evt code", vcode, 2);
    check("press evt press", vpress, 1);
    key_cur = 8'hFF; key = key_cur;
    wait_valid(30, ok);
    check("release evt seen", {31'd0, ok}, 1);
    check("release evt code", {29'd0, evt_code}, 2);
    check("release evt press", {31'd0, evt_press}, 0);
    @(negedge clk);
    check("release single", {31'd0, evt_valid}, 0);

    // 3: bounce on key 5, one level per tick
    vcnt = 0;
    for (int t = 0; t < 10; t++) begin
      key_cur[5] = (t % 2 == 1); key = key_cur;
      repeat (DV) begin
        @(negedge clk);
        if (evt_valid) vcnt++;
      end
    end
    check("bounce no evt", vcnt, 0);
    key_cur[5] = 1'b0; key = key_cur;
    wait_valid(40, ok);
    check("bounce evt seen", {31'd0, ok}, 1);
    check("bounce evt code", {29'd0, evt_code}, 5);
    check("bounce evt press", {31'd0, evt_press}, 1);

    // 4: keys 0, 3, 7 together under backpressure
    @(negedge clk);
    evt_ready = 1'b0;
    key_cur[0] = 0; key_cur[3] = 0; key_cur[7] = 0; key = key_cur;
    wait_valid(40, ok);
    check("simul evt seen", {31'd0, ok}, 1);
    repeat (3) @(negedge clk);
    check("simul held valid", {31'd0, evt_valid}, 1);
    check("simul held code", {29'd0, evt_code}, 0);
    evt_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("simul xfer valid", {31'd0, evt_valid}, 1);
      check("simul xfer code", {29'd0, evt_code}, exp_codes[k]);
      @(negedge clk);
    end
    check("simul drained", {31'd0, evt_valid}, 0);

    // 5: cancel key 4 behind an unaccepted key-1 event
    evt_ready = 1'b0;
    key_cur[1] = 0; key = key_cur;
    wait_valid(40, ok);
    check("cancel k1 code", {29'd0, evt_code}, 1);
    key_cur[4] = 0; key = key_cur;
    wait_db_bit(4, 1'b0, 40, n);
    check("cancel k4 pressed", {31'd0, key_db[4]}, 0);
    key_cur[4] = 1; key = key_cur;
    wait_db_bit(4, 1'b1, 40, n);
    check("cancel k4 released", {31'd0, key_db[4]}, 1);
    check("cancel still k1", {29'd0, evt_code}, 1);
    evt_ready = 1'b1;
    @(negedge clk);
    vcnt = 0;
    repeat (20) begin
      if (evt_valid) vcnt++;
      @(negedge clk);
    end
    check("cancel no k4 evt", vcnt, 0);

    // 6: reset with an event presented and another pending
    evt_ready = 1'b0;
    key_cur[2] = 0; key_cur[6] = 0; key = key_cur;
    wait_valid(40, ok);
    check("midreset evt code", {29'd0, evt_code}, 2);
    reset = 1'b1; key_cur = 8'hFF; key = key_cur;
    @(negedge clk);
    check("midreset evt_valid", {31'd0, evt_valid}, 0);
    check("midreset key_db", {24'd0, key_db}, 32'hFF);
    @(negedge clk);
    reset = 1'b0; evt_ready = 1'b1;
    vcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (evt_valid) vcnt++;
    end
    check("midreset no stale", vcnt, 0);

    // Randomized traffic checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) key_cur[$urandom_range(0, NK - 1)] ^= 1'b1;
      key       = key_cur;
      evt_ready = ($urandom_range(0, 2) != 0);
      reset     = ($urandom_range(0, 999) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/key_event_debounce.md
# key_event_debounce

Debounces and synchronizes the raw, active-low 8-key push-button bank and turns every debounced transition into a queued press/release event with a valid/ready handshake. It sits directly upstream of the key-to-LED decoding stage, which consumes either the clean level vector `key_db` or the event stream. All timing is derived from a free-running sample tick, so decoding logic never sees bounce or metastable inputs.

## Interface
- `N_KEYS`, default 8: number of keys.
- `CW`, default 3: event code width, equal to clog2(N_KEYS).
- `DIV`, default 2000: clk cycles per sample tick, minimum 2.
- `STABLE`, default 4: consecutive differing samples needed to accept a new level, minimum 1.

- `clk`, input, 1: system clock. This is the only clock.
- `reset`, input, 1: synchronous, active-high reset.
- `key`, input, N_KEYS: raw buttons, asynchronous, active-low (0 = pressed).
- `key_db`, output, N_KEYS: debounced level, active-low.
- `evt_valid`, output, 1: an event is presented.
- `evt_code`, output, CW: index of the key that changed.
- `evt_press`, output, 1: 1 = press (level went 1→0), 0 = release.
- `evt_ready`, input, 1: consumer accepts the event.

## Operation
- **Synchronizer:** two flops per key, both reset to 1. The result is `ks`.
- **Tick counter:** counts 0..DIV-1 and wraps. `tick` is high in the cycle where count == DIV-1. Reset sets the count to 0.
- **Per-key stability counter `sc[i]`:** width clog2(STABLE)+1. It is updated only on `tick`:
  - If `ks[i]` == `key_db[i]`: `sc[i]` ← 0.
  - Else if `sc[i]` == STABLE-1: `key_db[i]` ← `ks[i]`, `sc[i]` ← 0, and `chg[i]` = 1 for this cycle.
  - Else: `sc[i]` ← `sc[i]`+1.
- **Pending mask `pend`:** N_KEYS bits, reset 0. Each cycle `pend[i]` ← `pend[i]` XOR `chg[i]`, except for the bit being loaded this cycle, which becomes `chg[i]`.
  - A key that toggles twice before its event is issued therefore cancels out, so no event is produced for it.
- **Output register:**
  - The slot is free when `evt_valid` == 0 or (`evt_valid` & `evt_ready`).
  - When the slot is free and `pend` != 0, the lowest set index i is loaded: `evt_code` ← i, `evt_press` ← ~`key_db[i]`, `evt_valid` ← 1.
  - When the slot is free and `pend` == 0, `evt_valid` ← 0.
  - While `evt_valid` & !`evt_ready`, `evt_code` and `evt_press` hold.
- **Event ordering:**
  - Keys changing on the same tick are reported in ascending index order, one per accepted transfer.
  - Back-to-back transfers sustain one event per cycle.
- No event is generated by reset itself.

## Timing
- **Reset values:** `key_db` = all 1, `evt_valid` = 0, `evt_code` = 0, `evt_press` = 0; all `sc`, `pend` and the tick counter are 0.
- **Reset mid-operation:** it clears all state in the same edge and drops `evt_valid` even if the event was not accepted. Pending events are lost.
- **Input to `key_db` latency:**
  - 2 cycles of synchronization, then STABLE ticks.
  - A clean step is accepted at the STABLE-th tick edge after it reaches `ks`.
  - Worst case: 2 + STABLE·DIV cycles.
- **`key_db` to `evt_valid`:** `key_db[i]` and `pend[i]` update at edge E. `evt_valid` rises at edge E+1 if the slot is free at E+1.
- **Bounce rejection:** any `ks` sample equal to `key_db` resets the count. Glitches shorter than STABLE consecutive ticks never reach `key_db`.
- **Tick wrap:** DIV-1 → 0 with no skipped or doubled tick.
- **Combinational paths:** none. All outputs are registered, and `evt_ready` affects state only at the clock edge.

## Test plan
Run the bench with DIV=4, STABLE=3.

1. **Reset:** hold `reset` for 3 cycles with `key`=8'hFE → `key_db`=8'hFF and `evt_valid`=0 during reset and on the first cycle after.
2. **Clean press:** apply `key`=8'hFB with `evt_ready`=1.
   - → `key_db`=8'hFB after 3 ticks (≤14 cycles).
   - → Exactly one cycle of `evt_valid`=1 with `evt_code`=2, `evt_press`=1.
   - Releasing to 8'hFF then gives one event with code 2 and `evt_press`=0.
3. **Bounce:** toggle `key[5]` every tick for 10 ticks, then hold it at 0.
   - → No event during toggling.
   - → One press event (code 5) exactly 3 ticks after the level settles.
4. **Simultaneous changes with backpressure:** change keys 0, 3 and 7 to pressed on the same tick while `evt_ready`=0.
   - → `evt_valid`=1 with code 0, held stable.
   - Then raise `evt_ready` for 3 cycles → codes 0, 3, 7 on consecutive transfers, then `evt_valid`=0.
5. **Cancel:** with `evt_ready`=0 and an unaccepted event for key 1 in the register, press and then release key 4 (each debounced).
   - → After `evt_ready`=1, only the key 1 event is delivered; `pend`=0 and no key 4 event appears.
6. **Reset mid-event:** assert `reset` while `evt_valid`=1 and `pend`≠0.
   - → Next cycle `evt_valid`=0, `key_db`=8'hFF, and no stale events after reset is released with `key`=8'hFF.
